// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package riscv_mem_pkg;

  // Default memory read latency, issue cycle to valid read data.
  localparam int MEM_LAT_DEFAULT = 2;

  // Latency counter width; supports MEM_LAT values 1..15.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

endpackage

// File: rtl/arb_select.sv
// Winner selection between the fetch and data requesters.
// With MEM_ARB_RR_EN defined, simultaneous requests alternate using a
// last-owner register (reset value IF, so data wins the first tie).
// Otherwise data has fixed priority over fetch and no state is kept.
module arb_select
  import riscv_mem_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic   clk,
  input  logic   reset,
  input  logic   issue,
`endif
  input  logic   if_req,
  input  logic   dm_req,
  output owner_t winner
);

`ifdef MEM_ARB_RR_EN
  owner_t last_owner_reg;

  // Remember who was granted last, updated on every issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg <= OWN_IF;
    end else if (issue) begin
      last_owner_reg <= winner;
    end
  end

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    winner = OWN_IF;
    if (if_req && dm_req) begin
      winner = (last_owner_reg == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (dm_req) begin
      winner = OWN_DM;
    end
  end
`else
  // Data beats fetch whenever both are asking.
  always_comb begin
    winner = dm_req ? OWN_DM : OWN_IF;
    if (!if_req && !dm_req) begin
      winner = OWN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported unified instruction/data memory.
// One access is outstanding at a time; the fixed read latency is counted out
// and the response is returned from a register, so mem_rdata never reaches an
// output combinationally. A new access may issue in the response cycle.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on simultaneous requests).
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [63:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  // Counter is loaded in the issue cycle and reaches zero in issue+MEM_LAT.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  owner_t             owner_reg, owner_next;
  logic [63:0]        rdata_reg, rdata_next;
  owner_t             winner;
  logic               issue;

  arb_select u_arb_select (
`ifdef MEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
    .issue  (issue),
`endif
    .if_req (if_req),
    .dm_req (dm_req),
    .winner (winner)
  );

  // State, counter, owner and response data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      owner_reg <= OWN_IF;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      rdata_reg <= rdata_next;
    end
  end

  // Next-state logic, response pulses and same-cycle issue to memory.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    owner_next = owner_reg;
    rdata_next = rdata_reg;
    issue      = 1'b0;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_valid   = 1'b0;
    dm_done    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_reg)
      WAIT: begin
        if (cnt_reg == '0) begin
          rdata_next = mem_rdata;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RESP: begin
        // Reset in the response cycle suppresses the pulse.
        if_valid   = !reset && (owner_reg == OWN_IF);
        dm_done    = !reset && (owner_reg == OWN_DM);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Arbitration runs in IDLE and, for back-to-back issue, in RESP.
    if ((state_reg == IDLE || state_reg == RESP) && (if_req || dm_req) && !reset) begin
      issue      = 1'b1;
      mem_en     = 1'b1;
      owner_next = winner;
      cnt_next   = CNT_LOAD;
      state_next = WAIT;
      if (winner == OWN_DM) begin
        dm_gnt    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        if_gnt    = 1'b1;
        mem_addr  = if_addr;
      end
    end
  end

  assign if_rdata  = rdata_reg[31:0];
  assign dm_rdata  = rdata_reg;
  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: a MEM_LAT=2 instance and a
// MEM_LAT=1 instance, each fed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [63:0] GARB = 64'hBADB_ADBA_DBAD_BADB;

  logic        clk;
  logic        reset;

  // MEM_LAT = 2 instance signals
  logic        if_req, if_gnt, if_valid;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_done;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, pipe_q;
  logic        stall_if, stall_mem;

  // MEM_LAT = 1 instance signals
  logic        if_req_1, if_gnt_1, if_valid_1;
  logic [63:0] if_addr_1;
  logic [31:0] if_rdata_1;
  logic        dm_req_1, dm_we_1, dm_gnt_1, dm_done_1;
  logic [63:0] dm_addr_1, dm_wdata_1, dm_rdata_1;
  logic        mem_en_1, mem_we_1;
  logic [63:0] mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        stall_if_1, stall_mem_1;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.MEM_LAT(2), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.MEM_LAT(1), .ADDR_W(64)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_gnt(if_gnt_1), .if_valid(if_valid_1), .if_rdata(if_rdata_1),
    .dm_req(dm_req_1), .dm_we(dm_we_1), .dm_addr(dm_addr_1), .dm_wdata(dm_wdata_1),
    .dm_gnt(dm_gnt_1), .dm_done(dm_done_1), .dm_rdata(dm_rdata_1),
    .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .stall_if(stall_if_1), .stall_mem(stall_mem_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: 0x10 holds an addi instruction, everything else a pattern.
  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (a == 64'h10) return 64'h0000_0000_00A0_0093;
    return {32'h1234_0000 ^ a[31:0], 32'h0000_1000 + a[31:0]};
  endfunction

  // Read data valid exactly MEM_LAT cycles after the issue cycle, garbage otherwise.
  always @(posedge clk) begin
    pipe_q      <= (mem_en && !mem_we) ? mem_val(mem_addr) : GARB;
    mem_rdata   <= pipe_q;
    mem_rdata_1 <= (mem_en_1 && !mem_we_1) ? mem_val(mem_addr_1) : GARB;
  end

  // One line per completed transaction.
  always @(negedge clk) begin
    if (if_valid)   $display("[%0t] lat2 fetch done  rdata=%h", $time, if_rdata);
    if (dm_done)    $display("[%0t] lat2 data  done  rdata=%h", $time, dm_rdata);
    if (if_valid_1) $display("[%0t] lat1 fetch done  rdata=%h", $time, if_rdata_1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [1:0] exp_gnt, prev_gnt;

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_req_1 = 0; if_addr_1 = 0; dm_req_1 = 0; dm_we_1 = 0; dm_addr_1 = 0; dm_wdata_1 = 0;
    prev_gnt = 2'b00;

    // ---- reset state ----
    tick(); tick();
    if_req = 1'b1; settle();
    check_eq("rst_mem_en",  mem_en,   0);
    check_eq("rst_if_gnt",  if_gnt,   0);
    check_eq("rst_if_vld",  if_valid, 0);
    check_eq("rst_dm_done", dm_done,  0);
    check_eq("rst_if_rd",   if_rdata, 0);
    check_eq("rst_dm_rd",   dm_rdata, 0);
    check_eq("rst_maddr",   mem_addr, 0);
    if_req = 1'b0;
    tick(); reset = 1'b0;

    // ---- fetch only, addr 0x10 ----
    tick(); if_req = 1'b1; if_addr = 64'h10; settle();
    check_eq("f_gnt_T",    if_gnt,   1);
    check_eq("f_en_T",     mem_en,   1);
    check_eq("f_we_T",     mem_we,   0);
    check_eq("f_addr_T",   mem_addr, 64'h10);
    check_eq("f_stall_T",  stall_if, 1);
    tick();
    check_eq("f_gnt_T1",   if_gnt,   0);
    check_eq("f_addr_T1",  mem_addr, 0);
    check_eq("f_stall_T1", stall_if, 1);
    tick();
    check_eq("f_vld_T2",   if_valid, 0);
    check_eq("f_stall_T2", stall_if, 1);
    tick();
    check_eq("f_vld_T3",   if_valid, 1);
    check_eq("f_rd_T3",    if_rdata, 64'h00A0_0093);
    check_eq("f_stall_T3", stall_if, 0);
    if_req = 1'b0; settle();
    check_eq("f_noreiss",  mem_en,   0);

    // ---- store 0xDEAD to 0x40 ----
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'hDEAD; settle();
    check_eq("s_gnt_T",   dm_gnt,    1);
    check_eq("s_en_T",    mem_en,    1);
    check_eq("s_we_T",    mem_we,    1);
    check_eq("s_addr_T",  mem_addr,  64'h40);
    check_eq("s_wd_T",    mem_wdata, 64'hDEAD);
    check_eq("s_stall_T", stall_mem, 1);
    tick();
    check_eq("s_we_T1",   mem_we,    0);
    check_eq("s_wd_T1",   mem_wdata, 0);
    tick();
    check_eq("s_done_T2", dm_done,   0);
    tick();
    check_eq("s_done_T3", dm_done,   1);
    check_eq("s_ifv_T3",  if_valid,  0);
    check_eq("s_stl_T3",  stall_mem, 0);
    dm_req = 1'b0; dm_we = 1'b0;

    // ---- contention from a fresh reset: both requesters continuous ----
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    tick(); if_req = 1'b1; if_addr = 64'h20; dm_req = 1'b1; dm_addr = 64'h80; settle();
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (RR && k[0]) ? 2'b01 : 2'b10;   // {dm, if}
      check_eq($sformatf("arb_gnt%0d", k), {62'b0, dm_gnt, if_gnt}, {62'b0, exp_gnt});
      if (k > 0)
        check_eq($sformatf("arb_rsp%0d", k), {62'b0, dm_done, if_valid}, {62'b0, prev_gnt});
      if (k == 1)
        check_eq("arb_dm_rd", dm_rdata, {32'h1234_0080, 32'h0000_1080});
      if (k == 2 && RR)
        check_eq("arb_if_rd", {32'b0, if_rdata}, 64'h0000_1020);
      prev_gnt = exp_gnt;
      tick();
      check_eq($sformatf("arb_idle%0d", k), {62'b0, dm_gnt, if_gnt}, 0);
      tick(); tick();
    end
    if_req = 1'b0; dm_req = 1'b0; settle();
    // Last access still completes even though requests dropped.
    check_eq("arb_last_rsp", {62'b0, dm_done, if_valid}, {62'b0, prev_gnt});

    // ---- reset in the middle of a load ----
    tick(); dm_req = 1'b1; dm_addr = 64'h80; settle();
    check_eq("r_gnt_T",  dm_gnt, 1);
    tick(); reset = 1'b1; settle();
    check_eq("r_en_T1",  mem_en, 0);
    tick(); reset = 1'b0; dm_req = 1'b0; settle();
    check_eq("r_en_T2",   mem_en,   0);
    check_eq("r_done_T2", dm_done,  0);
    check_eq("r_ifv_T2",  if_valid, 0);
    check_eq("r_drd_T2",  dm_rdata, 0);
    check_eq("r_ird_T2",  if_rdata, 0);
    check_eq("r_stl_T2",  stall_mem, 0);
    tick(); if_req = 1'b1; if_addr = 64'h10; settle();
    check_eq("r_done_T3", dm_done, 0);
    check_eq("r_fgnt_T3", if_gnt,  1);
    tick(); tick(); tick();
    check_eq("r_fvld_T6", if_valid, 1);
    check_eq("r_frd_T6",  if_rdata, 64'h00A0_0093);
    if_req = 1'b0;

    // ---- MEM_LAT = 1: back-to-back fetches at 0x0 and 0x4 ----
    tick(); if_req_1 = 1'b1; if_addr_1 = 64'h0; settle();
    check_eq("l1_gnt_T",   if_gnt_1,   1);
    check_eq("l1_addr_T",  mem_addr_1, 0);
    tick();
    check_eq("l1_gnt_T1",  if_gnt_1,   0);
    check_eq("l1_vld_T1",  if_valid_1, 0);
    tick(); if_addr_1 = 64'h4; settle();
    check_eq("l1_vld_T2",  if_valid_1, 1);
    check_eq("l1_rd_T2",   {32'b0, if_rdata_1}, 64'h0000_1000);
    check_eq("l1_gnt_T2",  if_gnt_1,   1);
    check_eq("l1_addr_T2", mem_addr_1, 64'h4);
    tick();
    check_eq("l1_vld_T3",  if_valid_1, 0);
    tick();
    check_eq("l1_vld_T4",  if_valid_1, 1);
    check_eq("l1_rd_T4",   {32'b0, if_rdata_1}, 64'h0000_1004);
    if_req_1 = 1'b0; settle();
    check_eq("l1_end_en",  mem_en_1,   0);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
